seg_count_monitor: RTL and testbench

- Sits on the far end of the 60-second timer's display interface and reads back the two 9-bit seven-segment buses.
- Decodes the buses into BCD tens/units and checks that the displayed value advances legally: +1, wrap 59->0, or restart to 00.
- Counts steps and raises a sticky error on any illegal jump.
- Used in board self-test and as a bench checker for the timer.

---
 rtl/seg_count_monitor_if.sv | 30 +++
 rtl/seg_count_monitor.sv | 181 ++++++++++++++++++
 tb/tb_seg_count_monitor.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_count_monitor_if.sv
// rtl/seg_count_monitor_if.sv - display readback and monitor result bundle
// The timer side drives the segment buses and err_clr; the monitor returns decoded status.
interface seg_count_monitor_if #(
  parameter int CNT_W = 16
);
  logic [8:0]       segment_led_1;
  logic [8:0]       segment_led_2;
  logic             err_clr;
  logic [3:0]       value_tens;
  logic [3:0]       value_units;
  logic             value_valid;
  logic             step_pulse;
  logic             wrap_pulse;
  logic             restart_pulse;
  logic             decode_error;
  logic             seq_error;
  logic [CNT_W-1:0] step_count;

  modport master (
    output segment_led_1, segment_led_2, err_clr,
    input  value_tens, value_units, value_valid, step_pulse, wrap_pulse,
           restart_pulse, decode_error, seq_error, step_count
  );

  modport slave (
    input  segment_led_1, segment_led_2, err_clr,
    output value_tens, value_units, value_valid, step_pulse, wrap_pulse,
           restart_pulse, decode_error, seq_error, step_count
  );
endinterface

// File: rtl/seg_count_monitor.sv
// rtl/seg_count_monitor.sv - seven-segment readback decoder and count sequence checker
// Filters the two digit buses for stability, decodes them and checks for +1/wrap/restart steps.
module seg_count_monitor #(
  parameter int STABLE_CYCLES = 2,
  parameter int MAX_VALUE     = 59,
  parameter int CNT_W         = 16
) (
  input logic               clk_in,
  input logic               rst_n_in,
  seg_count_monitor_if.slave mon
);

  typedef enum logic [1:0] {WAIT_FIRST, TRACK, FAULT} state_e;

  localparam logic [3:0] STAB_LAST = 4'(STABLE_CYCLES - 1);
  localparam logic [6:0] MAX_V     = 7'(MAX_VALUE);
  localparam logic [6:0] MAX_TENS  = 7'(MAX_VALUE / 10);

  state_e           state_q, state_d;
  logic [17:0]      sample_q, sample_d;
  logic [17:0]      last_q, last_d;
  logic [3:0]       stab_q, stab_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       units_q, units_d;
  logic             valid_q, valid_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             restart_q, restart_d;
  logic             dec_err_q, dec_err_d;
  logic             seq_err_q, seq_err_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [17:0] in_pat;
  logic [4:0]  dec_t, dec_u;
  logic [6:0]  new_val, old_val;
  logic        pat_ok, accept, is_step, is_wrap, is_restart;

  // Returns {decodable, digit}; a blanked digit (SEG high) is never decodable.
  function automatic logic [4:0] seg_decode(input logic [8:0] seg);
    logic [4:0] r;
    r = 5'h00;
    if (!seg[8]) begin
      case (seg[6:0])
        7'h3F: r = {1'b1, 4'd0};
        7'h06: r = {1'b1, 4'd1};
        7'h5B: r = {1'b1, 4'd2};
        7'h4F: r = {1'b1, 4'd3};
        7'h66: r = {1'b1, 4'd4};
        7'h6D: r = {1'b1, 4'd5};
        7'h7D: r = {1'b1, 4'd6};
        7'h07: r = {1'b1, 4'd7};
        7'h7F: r = {1'b1, 4'd8};
        7'h6F: r = {1'b1, 4'd9};
        default: r = 5'h00;
      endcase
    end
    return r;
  endfunction

  assign in_pat = {mon.segment_led_1, mon.segment_led_2};

  always_comb begin
    dec_t      = seg_decode(sample_q[17:9]);
    dec_u      = seg_decode(sample_q[8:0]);
    new_val    = {3'b000, dec_t[3:0]} * 7'd10 + {3'b000, dec_u[3:0]};
    old_val    = {3'b000, tens_q} * 7'd10 + {3'b000, units_q};
    pat_ok     = dec_t[4] && dec_u[4] && ({3'b000, dec_t[3:0]} <= MAX_TENS) && (new_val <= MAX_V);
    accept     = (stab_q == STAB_LAST) && (sample_q != last_q);
    is_wrap    = (old_val == MAX_V) && (new_val == 7'd0);
    is_step    = (old_val < MAX_V) && (new_val == old_val + 7'd1);
    is_restart = (new_val == 7'd0) && (old_val != MAX_V);
  end

  // Stability filter; a pattern discarded by err_clr does not become last-accepted.
  always_comb begin
    sample_d = in_pat;
    stab_d   = 4'd0;
    if (in_pat == sample_q) begin
      stab_d = (stab_q == 4'hF) ? stab_q : stab_q + 4'd1;
    end
    last_d = last_q;
    if (accept && !mon.err_clr) begin
      last_d = sample_q;
    end
  end

  always_comb begin
    state_d = state_q;
    if (mon.err_clr) begin
      state_d = WAIT_FIRST;
    end else if (accept && pat_ok) begin
      case (state_q)
        WAIT_FIRST: state_d = TRACK;
        TRACK:      if (!(is_step || is_wrap || is_restart)) state_d = FAULT;
        default:    state_d = state_q;
      endcase
    end
  end

  always_comb begin
    tens_d    = tens_q;
    units_d   = units_q;
    valid_d   = valid_q;
    seq_err_d = seq_err_q;
    step_d    = 1'b0;
    wrap_d    = 1'b0;
    restart_d = 1'b0;
    dec_err_d = 1'b0;
    if (mon.err_clr) begin
      valid_d   = 1'b0;
      seq_err_d = 1'b0;
    end else if (accept) begin
      if (!pat_ok) begin
        dec_err_d = 1'b1;
      end else begin
        tens_d  = dec_t[3:0];
        units_d = dec_u[3:0];
        case (state_q)
          WAIT_FIRST: valid_d = 1'b1;
          TRACK: begin
            if (is_wrap) begin
              step_d = 1'b1;
              wrap_d = 1'b1;
            end else if (is_step) begin
              step_d = 1'b1;
            end else if (is_restart) begin
              restart_d = 1'b1;
            end else begin
              seq_err_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
    count_d = (step_d && (count_q != {CNT_W{1'b1}})) ? count_q + CNT_W'(1) : count_q;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= WAIT_FIRST;
      sample_q  <= '1;
      last_q    <= '1;
      stab_q    <= 4'd0;
      tens_q    <= 4'd0;
      units_q   <= 4'd0;
      valid_q   <= 1'b0;
      step_q    <= 1'b0;
      wrap_q    <= 1'b0;
      restart_q <= 1'b0;
      dec_err_q <= 1'b0;
      seq_err_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      sample_q  <= sample_d;
      last_q    <= last_d;
      stab_q    <= stab_d;
      tens_q    <= tens_d;
      units_q   <= units_d;
      valid_q   <= valid_d;
      step_q    <= step_d;
      wrap_q    <= wrap_d;
      restart_q <= restart_d;
      dec_err_q <= dec_err_d;
      seq_err_q <= seq_err_d;
      count_q   <= count_d;
    end
  end

  assign mon.value_tens    = tens_q;
  assign mon.value_units   = units_q;
  assign mon.value_valid   = valid_q;
  assign mon.step_pulse    = step_q;
  assign mon.wrap_pulse    = wrap_q;
  assign mon.restart_pulse = restart_q;
  assign mon.decode_error  = dec_err_q;
  assign mon.seq_error     = seq_err_q;
  assign mon.step_count    = count_q;

endmodule

// File: tb/tb_seg_count_monitor.sv
// tb/tb_seg_count_monitor.sv - scoreboard bench for seg_count_monitor
// Stimulus predicts visible events into a queue; a negedge monitor pops and compares them.
module tb_seg_count_monitor;

  localparam int S = 2;
  localparam logic [6:0] SEG_CODE [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;
  always #5 clk_in = ~clk_in;

  seg_count_monitor_if #(.CNT_W(16)) mif ();
  seg_count_monitor_if #(.CNT_W(4))  sif ();

  seg_count_monitor #(.STABLE_CYCLES(S), .MAX_VALUE(59), .CNT_W(16)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .mon(mif.slave));
  seg_count_monitor #(.STABLE_CYCLES(S), .MAX_VALUE(59), .CNT_W(4)) dut_sat (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .mon(sif.slave));

  typedef struct {
    int cyc; bit valid; int tens; int units; bit seq;
    bit step; bit wrap; bit restart; bit dec; int count;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Reference model state
  int          m_state = 0;
  bit          m_valid = 0;
  bit          m_seq   = 0;
  int          m_val   = 0;
  int          m_count = 0;
  logic [17:0] last_pat = '1;
  logic [17:0] cur_pat  = '0;
  int          run      = 0;

  task automatic chk(string name, int act, int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [8:0] enc(int d, bit dp);
    return {1'b0, dp, SEG_CODE[d]};
  endfunction

  function automatic logic [17:0] pat(int v, bit dp);
    return {enc(v / 10, dp), enc(v % 10, 1'b0)};
  endfunction

  function automatic int digit_of(logic [8:0] s);
    if (s[8]) return -1;
    for (int i = 0; i < 10; i++) if (s[6:0] == SEG_CODE[i]) return i;
    return -1;
  endfunction

  function automatic int model_value(logic [17:0] p);
    int t, u;
    t = digit_of(p[17:9]);
    u = digit_of(p[8:0]);
    if (t < 0 || u < 0 || t > 5 || t * 10 + u > 59) return -1;
    return t * 10 + u;
  endfunction

  task automatic emit(int at, bit st, bit wr, bit rs, bit de, bit changed);
    if (st || wr || rs || de || changed)
      q.push_back('{at, m_valid, m_val / 10, m_val % 10, m_seq, st, wr, rs, de, m_count});
  endtask

  task automatic model_accept(logic [17:0] p, int at);
    int v;
    bit st, wr, rs, de, pv, ps;
    int pval;
    v = model_value(p);
    st = 0; wr = 0; rs = 0; de = 0;
    pv = m_valid; ps = m_seq; pval = m_val;
    last_pat = p;
    if (v < 0) begin
      de = 1;
    end else begin
      if (m_state == 0) begin
        m_valid = 1;
        m_state = 1;
      end else if (m_state == 1) begin
        if (m_val == 59 && v == 0) begin st = 1; wr = 1; end
        else if (v == m_val + 1) st = 1;
        else if (v == 0) rs = 1;
        else begin m_seq = 1; m_state = 2; end
      end
      m_val = v;
    end
    if (st) m_count++;
    emit(at, st, wr, rs, de, (pv != m_valid) || (ps != m_seq) || (pval != m_val));
  endtask

  task automatic model_clear(int at);
    bit pv, ps;
    pv = m_valid; ps = m_seq;
    m_valid = 0; m_seq = 0; m_state = 0;
    emit(at, 0, 0, 0, 0, pv || ps);
  endtask

  task automatic set_in(logic [17:0] p, bit clr);
    mif.segment_led_1 = p[17:9];
    mif.segment_led_2 = p[8:0];
    mif.err_clr       = clr;
    sif.segment_led_1 = p[17:9];
    sif.segment_led_2 = p[8:0];
    sif.err_clr       = clr;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Hold p for n cycles; a pattern is accepted once it has been held S cycles.
  // err_clr is driven after tick clr_idx (clr_idx must be < n-1 or negative).
  task automatic hold(logic [17:0] p, int n, int clr_idx);
    bit acc;
    if (p != cur_pat) begin
      cur_pat = p;
      run = 0;
    end
    set_in(p, 1'b0);
    for (int i = 0; i < n; i++) begin
      tick();
      if (run < 1000) run++;
      acc = (run == S) && (cur_pat != last_pat);
      if (i == clr_idx) begin
        set_in(p, 1'b1);
        model_clear(cyc + 1);
      end else begin
        set_in(p, 1'b0);
        if (acc) model_accept(cur_pat, cyc + 1);
      end
    end
  endtask

  task automatic check_reset_values(string tag);
    chk({tag, "_valid"},   int'(mif.value_valid), 0);
    chk({tag, "_tens"},    int'(mif.value_tens), 0);
    chk({tag, "_units"},   int'(mif.value_units), 0);
    chk({tag, "_seq"},     int'(mif.seq_error), 0);
    chk({tag, "_pulses"},  int'({mif.step_pulse, mif.wrap_pulse, mif.restart_pulse, mif.decode_error}), 0);
    chk({tag, "_count"},   int'(mif.step_count), 0);
    chk({tag, "_satcnt"},  int'(sif.step_count), 0);
  endtask

  // Asynchronous reset asserted between clock edges, checked before the next edge.
  task automatic reset_mid(string tag);
    #2;
    rst_n_in = 1'b0;
    #1;
    check_reset_values(tag);
    q.delete();
    m_state = 0; m_valid = 0; m_seq = 0; m_val = 0; m_count = 0;
    last_pat = '1;
    tick();
    tick();
    rst_n_in = 1'b1;
    run = 0;
  endtask

  // Monitor
  bit   p_valid, p_seq;
  int   p_tens, p_units, p_count;
  bit   ev;
  exp_t e;
  always @(negedge clk_in) begin
    if (!rst_n_in) begin
      p_valid = 0; p_seq = 0; p_tens = 0; p_units = 0; p_count = 0;
    end else begin
      ev = mif.step_pulse || mif.wrap_pulse || mif.restart_pulse || mif.decode_error ||
           (mif.value_valid != p_valid) || (mif.seq_error != p_seq) ||
           (int'(mif.value_tens) != p_tens) || (int'(mif.value_units) != p_units) ||
           (int'(mif.step_count) != p_count);
      if (ev) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: got output change at cycle %0d expected none", cyc);
        end else begin
          e = q.pop_front();
          chk("ev_cycle",   cyc, e.cyc);
          chk("ev_valid",   int'(mif.value_valid), int'(e.valid));
          chk("ev_tens",    int'(mif.value_tens), e.tens);
          chk("ev_units",   int'(mif.value_units), e.units);
          chk("ev_seq",     int'(mif.seq_error), int'(e.seq));
          chk("ev_step",    int'(mif.step_pulse), int'(e.step));
          chk("ev_wrap",    int'(mif.wrap_pulse), int'(e.wrap));
          chk("ev_restart", int'(mif.restart_pulse), int'(e.restart));
          chk("ev_decerr",  int'(mif.decode_error), int'(e.dec));
          chk("ev_count",   int'(mif.step_count), e.count);
          chk("ev_satcnt",  int'(sif.step_count), (e.count > 15) ? 15 : e.count);
        end
      end
      p_valid = mif.value_valid;
      p_seq   = mif.seq_error;
      p_tens  = int'(mif.value_tens);
      p_units = int'(mif.value_units);
      p_count = int'(mif.step_count);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] p;
    int r, n, ci, v;
    bit dp;
    set_in(pat(0, 0), 1'b0);
    cur_pat = pat(0, 0);
    repeat (3) tick();
    check_reset_values("reset");
    rst_n_in = 1'b1;
    run = 0;

    hold(pat(0, 0), 3, -1);
    hold(pat(1, 0), 5, -1);
    hold(pat(57, 0), 5, -1);
    hold(pat(57, 0), 4, 1);
    for (int k = 58; k <= 63; k++) hold(pat(k % 60, 0), 5, -1);
    hold(pat(8, 0), 1, -1);
    hold(pat(4, 0), 5, -1);

    hold(pat(4, 0), 4, 1);
    hold(pat(22, 0), 5, -1);
    hold(pat(23, 0), 5, -1);
    hold(pat(0, 0), 5, -1);
    hold(pat(0, 0), 4, 1);
    hold(pat(23, 0), 5, -1);
    hold(pat(25, 0), 5, -1);
    hold(pat(26, 0), 5, -1);
    hold(pat(26, 0), 4, 1);
    hold(pat(30, 0), 5, -1);

    hold({enc(3, 0), 9'h049}, 5, -1);
    hold(pat(30, 0), 5, -1);
    hold(pat(30, 0), 4, 1);
    hold({enc(3, 0), 1'b1, 1'b0, SEG_CODE[0]}, 5, -1);
    hold(pat(30, 0), 5, -1);

    hold(pat(31, 0), 6, S - 1);
    hold(pat(31, 0), 3, -1);
    hold(pat(32, 0), 5, -1);

    hold(pat(33, 0), 1, -1);
    reset_mid("rst_filter");
    hold(pat(33, 0), 5, -1);
    hold(pat(10, 0), 5, -1);
    hold(pat(11, 0), 3, -1);
    reset_mid("rst_fault");
    hold(pat(11, 0), 5, -1);

    for (int k = 12; k < 37; k++) hold(pat(k, 0), S + $urandom_range(0, 2), -1);

    for (int k = 0; k < 400; k++) begin
      r  = $urandom_range(0, 19);
      dp = ($urandom_range(0, 7) == 0);
      n  = $urandom_range(1, 5);
      if (r < 11) begin
        p = pat((m_val + 1) % 60, dp);
      end else if (r < 13) begin
        p = pat(0, dp);
      end else if (r < 15) begin
        p = pat($urandom_range(0, 59), dp);
      end else if (r < 17) begin
        v = $urandom_range(0, 2);
        if (v == 0)      p = {enc(m_val / 10, 0), 1'b1, 1'b0, SEG_CODE[m_val % 10]};
        else if (v == 1) p = {enc($urandom_range(6, 9), 0), enc($urandom_range(0, 9), 0)};
        else             p = {enc(m_val / 10, 0), 2'b00, 7'($urandom_range(0, 127))};
      end else begin
        p = pat($urandom_range(0, 59), 0);
        n = 1;
      end
      ci = -1;
      if (n >= 3 && $urandom_range(0, 15) == 0) ci = $urandom_range(0, n - 2);
      hold(p, n, ci);
    end

    hold(cur_pat, 10, -1);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
